// File: rtl/riscvibe_pkg.sv
// Shared types for the forwarding scoreboard: in-flight producer tag entry
// and the fwd_sel "no forwarding" encoding.
package riscvibe_pkg;

    localparam int FWD_SEL_NONE = 0;

    // Wide enough for any producer-latency field up to 4 bits.
    localparam int TAG_REM_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [4:0]           rd;
        logic                 reg_write;
        logic [TAG_REM_W-1:0] rem;
    } fwd_tag_t;

endpackage

// File: rtl/fwd_src_match.sv
// Priority match of one source operand against all in-flight producer stages;
// the youngest matching stage wins and reports whether its result is still pending.
module fwd_src_match
    import riscvibe_pkg::*;
#(
    parameter int FWD_DEPTH = 3,
    parameter int SEL_W     = 2
) (
    input  logic                          i_rs_used,
    input  logic [4:0]                    i_rs_addr,
    input  fwd_tag_t [FWD_DEPTH-1:0]      i_tags,
    output logic [SEL_W-1:0]              o_hit_stage,
    output logic                          o_hit_busy
);

    // Scan oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        o_hit_stage = SEL_W'(FWD_SEL_NONE);
        o_hit_busy  = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (i_rs_used && i_tags[k].valid && i_tags[k].reg_write &&
                (i_tags[k].rd != 5'd0) && (i_tags[k].rd == i_rs_addr)) begin
                o_hit_stage = SEL_W'(k + 1);
                o_hit_busy  = (i_tags[k].rem != '0);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight producers, selects forwarding stages
// and stalls load-use hazards. Optional stall counter under FWD_SCOREBOARD_PERF_EN.
module fwd_scoreboard
    import riscvibe_pkg::*;
#(
    parameter  int NUM_SRC   = 2,
    parameter  int FWD_DEPTH = 3,
    parameter  int LAT_W     = 2,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           issue_valid,
    input  logic [NUM_SRC-1:0][4:0]        issue_rs_addr,
    input  logic [NUM_SRC-1:0]             issue_rs_used,
    input  logic [4:0]                     issue_rd_addr,
    input  logic                           issue_reg_write,
    input  logic [LAT_W-1:0]               issue_lat,
    input  logic                           flush,
    output logic                           issue_stall,
    output logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel
`ifdef FWD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]                    stall_cycles
`endif
);

    fwd_tag_t [FWD_DEPTH-1:0]       r_tags;
    logic [NUM_SRC-1:0][SEL_W-1:0]  w_hit_stage;
    logic [NUM_SRC-1:0]             w_hit_busy;
    logic                           w_accept;

    function automatic logic [TAG_REM_W-1:0] rem_dec(input logic [TAG_REM_W-1:0] rem);
        return (rem == '0) ? rem : rem - 1'b1;
    endfunction

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_src_match #(
            .FWD_DEPTH (FWD_DEPTH),
            .SEL_W     (SEL_W)
        ) u_match (
            .i_rs_used   (issue_rs_used[s]),
            .i_rs_addr   (issue_rs_addr[s]),
            .i_tags      (r_tags),
            .o_hit_stage (w_hit_stage[s]),
            .o_hit_busy  (w_hit_busy[s])
        );
    end

    always_comb begin
        issue_stall = issue_valid && (|w_hit_busy);
        for (int s = 0; s < NUM_SRC; s++) begin
            fwd_sel[s] = issue_stall ? SEL_W'(FWD_SEL_NONE) : w_hit_stage[s];
        end
    end

    assign w_accept = issue_valid && !issue_stall && !flush;

    // Payload fields shift freely; only valid/rem are reset, and reset beats flush beats issue.
    always_ff @(posedge clk) begin
        r_tags[0].rd        <= issue_rd_addr;
        r_tags[0].reg_write <= issue_reg_write;
        for (int k = 1; k < FWD_DEPTH; k++) begin
            r_tags[k].rd        <= r_tags[k-1].rd;
            r_tags[k].reg_write <= r_tags[k-1].reg_write;
        end
        if (rst) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                r_tags[k].valid <= 1'b0;
                r_tags[k].rem   <= '0;
            end
        end else begin
            r_tags[0].valid <= w_accept;
            r_tags[0].rem   <= TAG_REM_W'(issue_lat);
            for (int k = 1; k < FWD_DEPTH; k++) begin
                r_tags[k].valid <= r_tags[k-1].valid && !flush;
                r_tags[k].rem   <= rem_dec(r_tags[k-1].rem);
            end
        end
    end

`ifdef FWD_SCOREBOARD_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (issue_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter NUM_SRC, default 2, number of source operands checked per issued instruction.
REQ-002 Parameter FWD_DEPTH, default 3, number of tracked in-flight producer stages (stage 1 = youngest).
REQ-003 Parameter LAT_W, default 2, width of the producer-latency field.
REQ-004 Derived SEL_W = $clog2(FWD_DEPTH+1); a select value of 0 = no forwarding, k = forward from stage k.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 issue_valid  in  1  the instruction at the issue point requests issue.
REQ-009 issue_rs_addr  in  NUM_SRC x 5  source register addresses.
REQ-010 issue_rs_used  in  NUM_SRC  per-source flag: this source is actually read.
REQ-011 issue_rd_addr  in  5  destination register.
REQ-012 issue_reg_write  in  1  the instruction writes rd.
REQ-013 issue_lat  in  LAT_W  extra cycles after stage 1 before the result is forwardable (0 = ALU, 1 = load).
REQ-014 flush  in  1  squash all in-flight producers and the current issue.
REQ-015 issue_stall  out  1  issue is refused this cycle.
REQ-016 fwd_sel  out  NUM_SRC x SEL_W  per-source forwarding select.

Function
REQ-017 The block SHALL hold FWD_DEPTH tag entries {valid, rd, reg_write, rem[LAT_W]}; all entries shift one stage every cycle, and the oldest entry drops out.
REQ-018 accepted = issue_valid && !issue_stall && !flush; when accepted, stage 1 SHALL load {1, issue_rd_addr, issue_reg_write, issue_lat} the next cycle, otherwise stage 1 SHALL load a bubble (valid=0).
REQ-019 On each shift, entry k+1 SHALL receive entry k with rem decremented, saturating at 0.
REQ-020 Source s matches stage k when issue_rs_used[s], entry k valid, reg_write=1, rd!=0 and rd==issue_rs_addr[s].
REQ-021 For each source, the lowest-numbered matching stage (youngest producer) SHALL win; older matches are ignored.
REQ-022 A winning stage with rem!=0 SHALL raise issue_stall combinationally; any such source stalls the issue.
REQ-023 fwd_sel[s] SHALL be the winning stage number when issue_stall=0, and 0 when there is no match or when issue_stall=1.
REQ-024 Register x0 SHALL never match and never cause a stall.
REQ-025 issue_stall SHALL be 0 whenever issue_valid=0.
REQ-026 flush SHALL invalidate every entry at the next edge and force a bubble into stage 1; flush has priority over issue.
REQ-027 All outputs are combinational from the entries and the current inputs; there are zero cycles of latency from input to output.

Reset
REQ-028 rst SHALL clear every entry's valid and rem the next edge, giving issue_stall=0 and fwd_sel=0 on the following cycle for any input.
REQ-029 rst mid-stall SHALL release the stall after the reset edge; rst has priority over flush and issue.

Configuration
REQ-030 When FWD_SCOREBOARD_PERF_EN is defined, the block SHALL add the output stall_cycles[31:0]: it increments on every cycle with issue_stall=1, saturates at 32'hFFFFFFFF, and is cleared by rst.
REQ-031 When FWD_SCOREBOARD_PERF_EN is undefined, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 The fwd_sel encoding constant FWD_SEL_NONE=0 and the tag-entry struct typedef SHALL live in riscvibe_pkg.
REQ-033 The per-source priority match (REQ-020..023 for one source) SHALL be the sub-module fwd_src_match, instantiated NUM_SRC times by generate.

Verification
REQ-034 The bench SHALL issue ADD x5 (lat 0), then next cycle ADD x6,x5,x5 -> fwd_sel[0]=1, fwd_sel[1]=1, issue_stall=0.
REQ-035 The bench SHALL issue LW x7 (lat 1), then next cycle a user of x7 -> issue_stall=1 for 1 cycle, then fwd_sel[0]=2 with issue_stall=0.
REQ-036 The bench SHALL write x8 in consecutive cycles A then B, then issue a reader of x8 -> fwd_sel=1 (from B), not 2.
REQ-037 The bench SHALL issue a writer of x0 (lat 1), then a reader of x0 -> issue_stall=0, fwd_sel=0.
REQ-038 The bench SHALL issue LW x9 with flush asserted in the next cycle while a reader of x9 issues -> the cycle after the flush, the reader sees fwd_sel=0 and issue_stall=0.
REQ-039 With FWD_SCOREBOARD_PERF_EN defined, the bench SHALL drive 3 load-use stalls and then rst -> stall_cycles=3 before the reset and 0 after it.
